// File: rtl/keccak_squeeze.sv
// keccak_squeeze: squeeze stage that sits after the Keccak-f permutation core.
// It captures a permuted 1600-bit state and streams the rate lanes out as
// 64-bit digest words. When the digest is longer than one rate block, it asks
// the core for another permutation and waits for the next state.
//
// Optional build macro: KECCAK_SQUEEZE_BYTESWAP_EN
//   When defined, each output word is the selected lane with its bytes
//   reversed (lane byte 0 appears at out_data[63:56]).
//   When undefined, the lane is output unchanged.
//   Handshake and timing are the same in both builds.
//
// Parameters:
//   RATE_LANES  lanes in the rate (1..25), default 17 (SHA3-256)
//   OUT_WORDS   64-bit words per digest (1..255), default 4
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_state   permuted state; lane i at [1599-64*i -: 64], i = 5y+x
//   in_valid   in_state is valid
//   in_ready   state is captured this cycle if in_valid is high
//   perm_req   one-cycle pulse: another permutation is needed
//   out_data   digest word
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data
//   out_last   current word is the final digest word
//   busy       block is not idle
module keccak_squeeze #(
    parameter int unsigned RATE_LANES = 17,
    parameter int unsigned OUT_WORDS  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1599:0] in_state,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          perm_req,
    output logic [63:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy
);

    localparam int unsigned LANE_W   = 64;
    localparam int unsigned STATE_W  = 1600;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SEL_SIZE = 32;

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(RATE_LANES - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(OUT_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_PERM = 2'd2
    } state_t;

    state_t               state;
    logic [STATE_W-1:0]   buffer;
    logic [IDX_W-1:0]     lane_idx;
    logic [CNT_W-1:0]     word_cnt;

    logic [IDX_W-1:0]     lane_next;
    logic [CNT_W-1:0]     cnt_next;
    logic                 lane_end;
    logic [LANE_W-1:0]    rate_lane [SEL_SIZE];
    logic [LANE_W-1:0]    lane_sel;
    logic [LANE_W-1:0]    lane_out;

    assign lane_next = lane_idx + IDX_W'(1);
    assign cnt_next  = word_cnt + CNT_W'(1);
    assign lane_end  = (lane_idx == LAST_LANE);

    // Rate lanes as a lane-indexed table; slots past the rate read as zero so
    // capacity lanes can never reach the output.
    for (genvar i = 0; i < SEL_SIZE; i++) begin : g_lane
        if (i < RATE_LANES) begin : g_rate
            assign rate_lane[i] = buffer[STATE_W-1-LANE_W*i -: LANE_W];
        end else begin : g_pad
            assign rate_lane[i] = '0;
        end
    end

    // Capacity bits are held to mirror the full state but never read out.
    if (RATE_LANES < 25) begin : g_cap
        logic unused_cap;
        assign unused_cap = ^buffer[STATE_W-1-LANE_W*RATE_LANES:0];
    end

    assign lane_sel = rate_lane[lane_idx];

`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    // Byte-reverse the lane for a big-endian host byte stream.
    for (genvar b = 0; b < 8; b++) begin : g_swap
        assign lane_out[LANE_W-1-8*b -: 8] = lane_sel[8*b +: 8];
    end
`else
    assign lane_out = lane_sel;
`endif

    // Word mux from registered buffer and index; zero outside STREAM.
    assign out_data = out_valid ? lane_out : '0;

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            buffer    <= '0;
            lane_idx  <= '0;
            word_cnt  <= '0;
            perm_req  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            perm_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        buffer    <= in_state;
                        lane_idx  <= '0;
                        word_cnt  <= '0;
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        out_last  <= (OUT_WORDS == 1);
                        busy      <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        word_cnt <= cnt_next;
                        lane_idx <= lane_next;
                        if (out_last) begin
                            // Final word wins over a coincident lane wrap.
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else if (lane_end) begin
                            state     <= WAIT_PERM;
                            perm_req  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_last <= (cnt_next == LAST_WORD);
                        end
                    end
                end
                WAIT_PERM: begin
                    // word_cnt carries across permutations.
                    if (in_valid) begin
                        buffer    <= in_state;
                        lane_idx  <= '0;
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        out_last  <= (word_cnt == LAST_WORD);
                        in_ready  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
